instr_mem_block: RTL and testbench

INSTR_MEM_BLOCK -- requirements
Module: instr_mem

---
 rtl/instr_mem_block_pkg.sv | 47 ++++
 rtl/instr_mem_block_mem.sv | 64 ++++++
 rtl/instr_mem_block.sv | 31 +++
 tb/tb_instr_mem_block.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/instr_mem_block_pkg.sv
// Shared constants for the instruction memory: default depth, the NOP word,
// and the ten-word boot image loaded at reset and visible from power-up.
package instr_mem_block_pkg;

    // Number of instruction words when the parent does not override DEPTH.
    localparam int DEPTH_DEFAULT = 128;

    // Natural instruction width of the image and the NOP constant.
    localparam int WORD_WIDTH = 32;

    // Word returned for any address that falls outside the array.
    localparam logic [WORD_WIDTH-1:0] NOP = 32'h0000_0000;

    // Number of leading words that carry a non-zero boot value.
    localparam int IMAGE_LEN = 10;

    // Boot image; every word past the end of this table is NOP.
    localparam logic [WORD_WIDTH-1:0] DEFAULT_IMAGE [IMAGE_LEN] = '{
        32'hA000_00AA,
        32'h1000_0011,
        32'h2000_0022,
        32'h3000_0033,
        32'h4000_0044,
        32'h5000_0055,
        32'h6000_0066,
        32'h7000_0077,
        32'h8000_0088,
        32'h9000_0099
    };

    // Boot value of the word at index idx; anything past the table is NOP.
    function automatic logic [WORD_WIDTH-1:0] image_word(input logic [31:0] idx);
        logic [WORD_WIDTH-1:0] word;
        word = NOP;
        if (idx < 32'(IMAGE_LEN)) begin
            word = DEFAULT_IMAGE[idx[3:0]];
        end
        return word;
    endfunction

    // True when a full 32-bit word index selects a real storage location.
    // The whole address is compared so that upper bits never alias.
    function automatic logic in_range(input logic [31:0] idx, input int unsigned depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/instr_mem_block_mem.sv
// Instruction storage: flat register array with a combinational, bounds-checked
// read port, a clocked bounds-checked load port, and a synchronous reset that
// reloads the boot image. A per-word "loaded" bit lets reads show the boot
// image from power-up without relying on an initial block: until a word has
// been written or reset-loaded, its read value comes straight from the image.
module instr_mem
    import instr_mem_block_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    output logic [WIDTH-1:0] data,
    input  logic             we,
    input  logic [31:0]      waddr,
    input  logic [WIDTH-1:0] wdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // Power-up state: no word has been loaded yet, so reads fall back to the image.
    logic [DEPTH-1:0] loaded = '0;

    logic          read_ok;
    logic          write_ok;
    logic [AW-1:0] rindex;
    logic [AW-1:0] windex;

    assign read_ok  = in_range(addr, DEPTH);
    assign write_ok = we && in_range(waddr, DEPTH);
    assign rindex   = addr[AW-1:0];
    assign windex   = waddr[AW-1:0];

    // Reset reloads every word from the image and wins over a same-cycle write;
    // otherwise an in-range write updates one word and out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(image_word(32'(i)));
            end
            loaded <= '1;
        end else if (write_ok) begin
            mem[windex]    <= wdata;
            loaded[windex] <= 1'b1;
        end
    end

    // Zero-latency read: NOP outside the array, stored word once loaded, boot image before that.
    always_comb begin
        data = WIDTH'(NOP);
        if (read_ok) begin
            if (loaded[rindex]) begin
                data = mem[rindex];
            end else begin
                data = WIDTH'(image_word(addr));
            end
        end
    end

endmodule

// File: rtl/instr_mem_block.sv
// Top level of the instruction memory block. All storage and addressing
// logic lives in instr_mem; this level only fixes the parameters and ports.
module instr_mem_block
    import instr_mem_block_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    output logic [WIDTH-1:0] data,
    input  logic             we,
    input  logic [31:0]      waddr,
    input  logic [WIDTH-1:0] wdata
);

    instr_mem #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata)
    );

endmodule

// File: tb/tb_instr_mem_block.sv
// Self-checking bench for instr_mem_block: directed boot-image, bounds,
// write, reset and reset-priority steps, then randomized traffic compared
// against a word-array model of the memory.
module tb_instr_mem_block;

    localparam int DEPTH = 128;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    int tests_run;
    int tests_failed;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] boot_words [10];

    instr_mem_block #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Restore the model to the boot contents
    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = (i < 10) ? boot_words[i] : 32'h0;
        end
    endtask

    // Expected read value for any 32-bit word index
    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < DEPTH) return model_mem[a];
        return 32'h0;
    endfunction

    // Apply the effect of one rising edge to the model
    task automatic model_edge(input logic r, input logic w,
                              input logic [31:0] wa, input logic [31:0] wd);
        if (r) model_reset();
        else if (w && wa < DEPTH) model_mem[wa] = wd;
    endtask

    // Drive all DUT inputs at once
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] wa,
                                 input logic [31:0] wd, input logic [31:0] a);
        rst   = r;
        we    = w;
        waddr = wa;
        wdata = wd;
        addr  = a;
    endtask

    // Compare the read port against the expected word
    task automatic checkOutput(input string tag, input logic [31:0] expected);
        tests_run++;
        assert (data === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, data, expected);
        end
    endtask

    // One clocked step: drive at negedge, check before edge, clock, check after edge
    task automatic clockedStep(input string tag, input logic r, input logic w,
                               input logic [31:0] wa, input logic [31:0] wd,
                               input logic [31:0] a);
        @(negedge clk);
        applyStimulus(r, w, wa, wd, a);
        #1;
        checkOutput({tag, "_pre"}, model_read(a));
        @(posedge clk);
        model_edge(r, w, wa, wd);
        #1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, a);
        #1;
        checkOutput({tag, "_post"}, model_read(a));
    endtask

    initial begin
        logic        r_r;
        logic        r_w;
        logic [31:0] r_wa;
        logic [31:0] r_wd;
        logic [31:0] r_a;

        tests_run    = 0;
        tests_failed = 0;
        boot_words = '{32'hA00000AA, 32'h10000011, 32'h20000022, 32'h30000033,
                       32'h40000044, 32'h50000055, 32'h60000066, 32'h70000077,
                       32'h80000088, 32'h90000099};
        model_reset();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Boot image readable without any reset, addr stepped every 10 ns
        for (int i = 0; i < 10; i++) begin
            addr = 32'(i);
            #1;
            checkOutput($sformatf("boot_word%0d", i), boot_words[i]);
            #9;
        end

        // Out-of-range reads return NOP
        addr = 32'd10;          #1; checkOutput("read_10", 32'h0);
        addr = 32'(DEPTH);      #1; checkOutput("read_depth", 32'h0);
        addr = 32'hFFFF_FFFF;   #1; checkOutput("read_max", 32'h0);
        addr = 32'(DEPTH) + 32'd3; #1; checkOutput("read_alias3", 32'h0);

        // Write before any reset; read-during-write shows old then new
        clockedStep("write3", 1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF, 32'd3);
        addr = 32'd4; #1; checkOutput("neighbor4", 32'h40000044);

        // Reset restores the overwritten word
        clockedStep("reset_restore", 1'b1, 1'b0, 32'h0, 32'h0, 32'd3);

        // Reset wins over a same-edge write
        clockedStep("reset_vs_write", 1'b1, 1'b1, 32'd5, 32'h1234_5678, 32'd5);

        // Out-of-range write changes nothing
        clockedStep("oob_write", 1'b0, 1'b1, 32'(DEPTH), 32'hFFFF_FFFF, 32'd0);
        clockedStep("oob_write_hi", 1'b0, 1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < DEPTH; i++) begin
            addr = 32'(i);
            #1;
            checkOutput($sformatf("sweep%0d", i), (i < 10) ? boot_words[i] : 32'h0);
        end

        // Last word is writable
        clockedStep("write_last", 1'b0, 1'b1, 32'(DEPTH - 1), 32'hCAFE_F00D, 32'(DEPTH - 1));

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            r_r  = ($urandom_range(0, 19) == 0);
            r_w  = ($urandom_range(0, 3) != 0);
            r_wd = $urandom;
            case ($urandom_range(0, 9))
                0:       r_wa = $urandom;
                1:       r_wa = 32'(DEPTH) + 32'($urandom_range(0, 15));
                default: r_wa = 32'($urandom_range(0, DEPTH - 1));
            endcase
            case ($urandom_range(0, 9))
                0:       r_a = $urandom;
                1:       r_a = 32'(DEPTH) + 32'($urandom_range(0, 15));
                2, 3:    r_a = r_wa;
                default: r_a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            clockedStep($sformatf("rand%0d", n), r_r, r_w, r_wa, r_wd, r_a);
        end

        // Final full sweep against the model
        for (int i = 0; i < DEPTH; i++) begin
            addr = 32'(i);
            #1;
            checkOutput($sformatf("final%0d", i), model_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
